// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong datapath: play-state enum, screen size, coordinate widths.
package pong_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned SCOORD_W     = COORD_W + 1;
    localparam int unsigned BALL_WIDTH_W = 6;
    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } ball_state_t;

    // Signed working coordinate: wide enough to see a step past either screen edge.
    typedef logic signed [SCOORD_W-1:0] scoord_t;

endpackage

// File: rtl/ball_motion_if.sv
// Control/status bundle between the ball engine (slave) and the game logic driving it (master).
interface ball_motion_if;
    import pong_pkg::*;

    logic                    tick;
    logic                    serve;
    logic [COORD_W-1:0]      paddle_l_y;
    logic [COORD_W-1:0]      paddle_r_y;
    logic [COORD_W-1:0]      ball_x;
    logic [COORD_W-1:0]      ball_y;
    logic [BALL_WIDTH_W-1:0] ball_width;
    logic                    point_left;
    logic                    point_right;
    logic                    in_play;

    modport slave (
        input  tick, serve, paddle_l_y, paddle_r_y,
        output ball_x, ball_y, ball_width, point_left, point_right, in_play
    );

    modport master (
        output tick, serve, paddle_l_y, paddle_r_y,
        input  ball_x, ball_y, ball_width, point_left, point_right, in_play
    );

endinterface

// File: rtl/ball_paddle_hit.sv
// Combinational contact test between the ball's next x / current y and one paddle.
module ball_paddle_hit
    import pong_pkg::*;
#(
    parameter bit          RIGHT_SIDE = 1'b0,
    parameter int unsigned BALL_W     = 8,
    parameter int unsigned PADDLE_W   = 8,
    parameter int unsigned PADDLE_H   = 64,
    parameter int unsigned PADDLE_X   = 16
) (
    input  scoord_t            nx_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] paddle_y_i,
    output logic               hit_c_o
);

    localparam int unsigned VW = COORD_W + 1;

    logic          x_ok_c;
    logic          y_ok_c;
    logic [VW-1:0] ball_bot;
    logic [VW-1:0] pad_bot;
    scoord_t       nx_right;

    assign nx_right = nx_i + scoord_t'(BALL_W);
    assign ball_bot = {1'b0, y_i} + VW'(BALL_W);
    assign pad_bot  = {1'b0, paddle_y_i} + VW'(PADDLE_H);
    assign y_ok_c   = (ball_bot > {1'b0, paddle_y_i}) && ({1'b0, y_i} < pad_bot);

    // Ball's leading edge has reached the paddle face but has not fully passed it.
    generate
        if (RIGHT_SIDE) begin : g_right
            assign x_ok_c = (nx_right >= scoord_t'(PADDLE_X)) &&
                            (nx_i < scoord_t'(PADDLE_X + PADDLE_W));
        end else begin : g_left
            assign x_ok_c = (nx_i <= scoord_t'(PADDLE_X + PADDLE_W)) &&
                            (nx_right > scoord_t'(PADDLE_X));
        end
    endgenerate

    assign hit_c_o = x_ok_c && y_ok_c;

endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity/play-state engine for pong; feeds ball_x and ball_width to the score block.
// Optional BALL_SPEEDUP_EN: each paddle hit adds 1 to horizontal speed, capped at MAX_SPEED_X.
module ball_motion
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
    parameter int unsigned BALL_W      = 8,
    parameter int unsigned SPEED_X     = 4,
    parameter int unsigned SPEED_Y     = 2,
    parameter int unsigned PADDLE_H    = 64,
    parameter int unsigned PADDLE_W    = 8,
    parameter int unsigned PADDLE_XL   = 16,
    parameter int unsigned PADDLE_XR   = 616,
    parameter int unsigned MAX_SPEED_X = 12
) (
    input logic          clk,
    input logic          reset_n,
    ball_motion_if.slave bus
);

    localparam int unsigned CENTER_X   = (SCREEN_W - BALL_W) / 2;
    localparam int unsigned CENTER_Y   = (SCREEN_H - BALL_W) / 2;
    localparam int unsigned BASE_SPEED = (SPEED_X < MAX_SPEED_X) ? SPEED_X : MAX_SPEED_X;

    ball_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               dir_x_q, dir_x_d;   // 1 = moving right
    logic               dir_y_q, dir_y_d;   // 1 = moving down
    logic               point_l_q, point_l_d;
    logic               point_r_q, point_r_d;
    logic               in_play_q, in_play_d;
    logic [COORD_W-1:0] speed_x;
    logic               hit_l_c, hit_r_c;
    scoord_t            x_s, y_s, spd_s, nx, ny;

`ifdef BALL_SPEEDUP_EN
    logic [COORD_W-1:0] speed_q, speed_d;
    logic               bounce_c;

    assign bounce_c = (state_q == PLAY) && bus.tick &&
                      ((!dir_x_q && hit_l_c) || (dir_x_q && hit_r_c));

    // Speed returns to base whenever the ball goes back to SERVE.
    always_comb begin
        speed_d = speed_q;
        if (state_q == MISS) begin
            speed_d = COORD_W'(BASE_SPEED);
        end else if (bounce_c) begin
            speed_d = (speed_q >= COORD_W'(MAX_SPEED_X)) ? COORD_W'(MAX_SPEED_X)
                                                         : speed_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speed_q <= COORD_W'(BASE_SPEED);
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_x = speed_q;
`else
    assign speed_x = COORD_W'(BASE_SPEED);
`endif

    assign x_s   = scoord_t'({1'b0, x_q});
    assign y_s   = scoord_t'({1'b0, y_q});
    assign spd_s = scoord_t'({1'b0, speed_x});
    assign nx    = dir_x_q ? (x_s + spd_s) : (x_s - spd_s);
    assign ny    = dir_y_q ? (y_s + scoord_t'(SPEED_Y)) : (y_s - scoord_t'(SPEED_Y));

    ball_paddle_hit #(
        .RIGHT_SIDE (1'b0),
        .BALL_W     (BALL_W),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_X   (PADDLE_XL)
    ) u_hit_l (
        .nx_i       (nx),
        .y_i        (y_q),
        .paddle_y_i (bus.paddle_l_y),
        .hit_c_o    (hit_l_c)
    );

    ball_paddle_hit #(
        .RIGHT_SIDE (1'b1),
        .BALL_W     (BALL_W),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_X   (PADDLE_XR)
    ) u_hit_r (
        .nx_i       (nx),
        .y_i        (y_q),
        .paddle_y_i (bus.paddle_r_y),
        .hit_c_o    (hit_r_c)
    );

    // Next-state: paddle bounces win over misses; vertical walls are handled independently.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        point_l_d = 1'b0;
        point_r_d = 1'b0;
        case (state_q)
            SERVE: begin
                x_d = COORD_W'(CENTER_X);
                y_d = COORD_W'(CENTER_Y);
                if (bus.serve) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.tick) begin
                    if (!dir_x_q && hit_l_c) begin
                        x_d     = COORD_W'(PADDLE_XL + PADDLE_W);
                        dir_x_d = 1'b1;
                    end else if (dir_x_q && hit_r_c) begin
                        x_d     = COORD_W'(PADDLE_XR - BALL_W);
                        dir_x_d = 1'b0;
                    end else if (!dir_x_q && (nx <= scoord_t'(0))) begin
                        x_d       = '0;
                        dir_x_d   = 1'b1;
                        state_d   = MISS;
                        point_r_d = 1'b1;
                    end else if (dir_x_q && ((nx + scoord_t'(BALL_W)) >= scoord_t'(SCREEN_W))) begin
                        x_d       = COORD_W'(SCREEN_W - BALL_W);
                        dir_x_d   = 1'b0;
                        state_d   = MISS;
                        point_l_d = 1'b1;
                    end else begin
                        x_d = COORD_W'(nx);
                    end

                    if (ny <= scoord_t'(0)) begin
                        y_d     = '0;
                        dir_y_d = 1'b1;
                    end else if ((ny + scoord_t'(BALL_W)) >= scoord_t'(SCREEN_H)) begin
                        y_d     = COORD_W'(SCREEN_H - BALL_W);
                        dir_y_d = 1'b0;
                    end else begin
                        y_d = COORD_W'(ny);
                    end
                end
            end
            MISS: begin
                state_d = SERVE;
                x_d     = COORD_W'(CENTER_X);
                y_d     = COORD_W'(CENTER_Y);
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    assign in_play_d = (state_d == PLAY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SERVE;
            x_q       <= COORD_W'(CENTER_X);
            y_q       <= COORD_W'(CENTER_Y);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            in_play_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            point_l_q <= point_l_d;
            point_r_q <= point_r_d;
            in_play_q <= in_play_d;
        end
    end

    assign bus.ball_x      = x_q;
    assign bus.ball_y      = y_q;
    assign bus.ball_width  = BALL_WIDTH_W'(BALL_W);
    assign bus.point_left  = point_l_q;
    assign bus.point_right = point_r_q;
    assign bus.in_play     = in_play_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve, wall and paddle bounces, misses, async reset (default build).
module tb_ball_motion;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    ball_motion_if bus ();

    ball_motion dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick pulse per call, with an idle cycle before it; returns on the negedge after the tick edge.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 16'(bus.ball_x), 16'(ex));
        check({tag, "_y"}, 16'(bus.ball_y), 16'(ey));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b1;
        bus.tick       = 1'b0;
        bus.serve      = 1'b0;
        bus.paddle_l_y = 10'd240;
        bus.paddle_r_y = 10'd350;
        #1 reset_n = 1'b0;
        #1;
        check_pos("reset", 316, 236);
        check("reset_in_play", 16'(bus.in_play), 16'd0);
        check("reset_point_l", 16'(bus.point_left), 16'd0);
        check("reset_point_r", 16'(bus.point_right), 16'd0);
        check("ball_width", 16'(bus.ball_width), 16'd8);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick_n(1);
        check_pos("serve_hold", 316, 236);
        check("serve_hold_in_play", 16'(bus.in_play), 16'd0);

        // serve and tick together: enter PLAY without moving
        bus.serve = 1'b1;
        bus.tick  = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
        bus.tick  = 1'b0;
        check("serve_tick_in_play", 16'(bus.in_play), 16'd1);
        check_pos("serve_tick_nomove", 316, 236);

        tick_n(1);
        check_pos("first_tick", 320, 238);
        check("first_tick_in_play", 16'(bus.in_play), 16'd1);

        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
        check("serve_in_play_ignored", 16'(bus.in_play), 16'd1);
        check_pos("serve_in_play_nomove", 320, 238);

        // run toward the right paddle at y 350
        tick_n(71);
        check_pos("pre_right_hit", 604, 380);
        tick_n(1);
        check_pos("right_hit", 608, 382);
        tick_n(1);
        check_pos("right_hit_dir", 604, 384);
        bus.paddle_r_y = 10'd300;

        tick_n(44);
        check_pos("bottom_wall", 428, 472);
        tick_n(1);
        check_pos("bottom_wall_dir", 424, 470);

        // left paddle at y 240 overlaps ball y 272
        tick_n(99);
        check_pos("pre_left_hit", 28, 272);
        tick_n(1);
        check_pos("left_hit", 24, 270);
        tick_n(1);
        check_pos("left_hit_dir", 28, 268);

        tick_n(133);
        check_pos("near_top", 560, 2);
        tick_n(1);
        check_pos("top_wall", 564, 0);
        tick_n(1);
        check_pos("top_wall_dir", 568, 2);

        // right paddle moved away: ball runs off the right edge
        tick_n(15);
        check_pos("pre_right_miss", 628, 32);
        check("pre_right_miss_pl", 16'(bus.point_left), 16'd0);
        tick_n(1);
        check_pos("right_miss", 632, 34);
        check("right_miss_point_l", 16'(bus.point_left), 16'd1);
        check("right_miss_point_r", 16'(bus.point_right), 16'd0);
        check("right_miss_in_play", 16'(bus.in_play), 16'd0);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        check_pos("after_right_miss", 316, 236);
        check("after_right_miss_pl", 16'(bus.point_left), 16'd0);
        check("after_right_miss_in_play", 16'(bus.in_play), 16'd0);

        // serve leftward, left paddle out of the way
        bus.paddle_l_y = 10'd0;
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
        check("serve2_in_play", 16'(bus.in_play), 16'd1);
        tick_n(73);
        check_pos("left_zone", 24, 382);
        tick_n(1);
        check_pos("left_pass", 20, 384);
        tick_n(4);
        check_pos("pre_left_miss", 4, 392);
        tick_n(1);
        check_pos("left_miss", 0, 394);
        check("left_miss_point_r", 16'(bus.point_right), 16'd1);
        check("left_miss_point_l", 16'(bus.point_left), 16'd0);
        @(negedge clk);
        check_pos("after_left_miss", 316, 236);
        check("after_left_miss_pr", 16'(bus.point_right), 16'd0);

        // serve rightward, then async reset between edges
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
        tick_n(1);
        check_pos("serve3_tick", 320, 238);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_pos("async_reset", 316, 236);
        check("async_reset_in_play", 16'(bus.in_play), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick_n(1);
        check_pos("post_reset_hold", 316, 236);
        check("post_reset_in_play", 16'(bus.in_play), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Upstream stage of the pong score counter. Owns the ball's position, velocity and play state: advances the ball once per frame tick, bounces off top and bottom walls and both paddles, and detects misses. Drives `ball_x`/`ball_width` into the score block. A miss holds the ball at the screen edge for exactly one `clk` cycle, so the score counter increments exactly once per point.

## Interface
Parameters:
- `SCREEN_W`, 640: playfield width, pixels
- `SCREEN_H`, 480: playfield height, pixels
- `BALL_W`, 8: ball side length (square ball), ≤ 63
- `SPEED_X`, 4: horizontal pixels per tick
- `SPEED_Y`, 2: vertical pixels per tick
- `PADDLE_H`, 64: paddle height
- `PADDLE_W`, 8: paddle width
- `PADDLE_XL`, 16: left paddle left edge x
- `PADDLE_XR`, 616: right paddle left edge x
- `MAX_SPEED_X`, 12: speed-up ceiling (see Configuration)

Ports:
- `clk` in 1: system clock; one clock domain
- `reset_n` in 1: asynchronous, active-low reset
- `tick` in 1: one-cycle frame pulse; motion advances only on this pulse
- `serve` in 1: launch request; honoured only in SERVE
- `paddle_l_y` in 10: left paddle top y
- `paddle_r_y` in 10: right paddle top y
- `ball_x` out 10: ball left edge, registered
- `ball_y` out 10: ball top edge, registered
- `ball_width` out 6: constant `BALL_W`
- `point_left` out 1: one-cycle pulse when the left player scores (right-edge miss)
- `point_right` out 1: one-cycle pulse when the right player scores (left-edge miss)
- `in_play` out 1: high in PLAY state

## Operation
- States: SERVE, PLAY, MISS.
- Reset values: state SERVE; `ball_x`=(SCREEN_W−BALL_W)/2=316; `ball_y`=(SCREEN_H−BALL_W)/2=236; dir_x=+ (right); dir_y=+ (down); speed_x=`SPEED_X`; pulse outputs 0; `in_play` 0.
- SERVE: ball held at center. `serve`=1 moves the state to PLAY. dir_x is kept from the previous point.
- PLAY, on a `tick` cycle: compute nx=x±speed_x and ny=y±SPEED_Y in 11-bit signed. Checks are evaluated in priority order:
  1. Left paddle hit: dir_x=−, nx ≤ PADDLE_XL+PADDLE_W, nx+BALL_W > PADDLE_XL, and the vertical spans overlap (y+BALL_W > paddle_l_y and y < paddle_l_y+PADDLE_H). Result: x=PADDLE_XL+PADDLE_W, dir_x=+.
  2. Right paddle hit: the mirror case against PADDLE_XR. Result: x=PADDLE_XR−BALL_W, dir_x=−.
  3. Left miss: dir_x=− and nx ≤ 0. Result: x=0, state MISS, dir_x=+.
  4. Right miss: dir_x=+ and nx+BALL_W ≥ SCREEN_W. Result: x=SCREEN_W−BALL_W, state MISS, dir_x=−.
  5. Otherwise: x=nx.
- Vertical wall handling is independent of the x checks:
  - ny ≤ 0: y=0, dir_y=+.
  - ny+BALL_W ≥ SCREEN_H: y=SCREEN_H−BALL_W, dir_y=−.
- PLAY with `tick`=0: no change.
- MISS: lasts exactly one `clk` cycle regardless of `tick`. `point_right` or `point_left` is high during that cycle. Next cycle: state SERVE and the ball recentered.

## Timing
- All outputs are registered; position changes in the cycle after the `tick` edge.
- Overlap checks use the current registered y, not ny.
- `serve` and `tick` together in SERVE: state goes to PLAY, with no motion on that tick.
- `serve` outside SERVE is ignored. `tick` in MISS is ignored.
- Paddle inputs are sampled only on `tick` cycles in PLAY.
- `reset_n` low at any time returns to the reset values immediately, without waiting for a clock edge.

## Configuration
- `BALL_SPEEDUP_EN` defined: each paddle hit increments speed_x by 1, saturating at `MAX_SPEED_X`. Entering SERVE restores `SPEED_X`.
- Macro undefined: speed_x is constant at `SPEED_X`, and the speed register is omitted.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum `ball_state_t` (SERVE, PLAY, MISS)
  - the screen-size defaults SCREEN_W and SCREEN_H
  - the coordinate width constant (10)
- Sub-module `ball_paddle_hit` is a combinational span/overlap check (ball x/y, paddle x/y → hit). It is instantiated twice, once per paddle.

## Test plan
- Reset then `serve` then 1 tick → `ball_x`=320, `ball_y`=238, `in_play`=1.
- Ball at y=2 moving up, 1 tick → `ball_y`=0, then the next tick → `ball_y`=2 (dir_y flipped).
- Ball at x=26 moving left, `paddle_l_y`=200, `ball_y`=220, tick → `ball_x`=24 and dir_x=+. Repeat with `paddle_l_y`=0 → ball passes the paddle without bouncing.
- Ball at x=630 moving right, no paddle overlap, tick → `ball_x`=632 with `point_left` high for exactly 1 cycle, then `ball_x`=316 and state SERVE. The downstream score increments once.
- `reset_n` asserted mid-PLAY between clock edges → outputs return to center immediately. `serve` asserted during PLAY → no effect.
- With `BALL_SPEEDUP_EN`: 10 consecutive paddle hits → speed_x saturates at 12; the next serve → speed_x=4.
